// File: rtl/sound_store_rx.sv
// sound_store_rx: serial byte receiver that packs bytes little-endian into words
// and stores them in a circular RAM with an independent registered read port.
// Optional feature macro: SOUND_STORE_PARITY_EN (8E1 frames with even-parity check).
module sound_store_rx #(
  parameter int unsigned CLKS_PER_BIT   = 48,
  parameter int unsigned BYTES_PER_WORD = 2,
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned WRAP_WORDS     = 1000,
  localparam int unsigned AW            = $clog2(DEPTH),
  localparam int unsigned DW            = 8 * BYTES_PER_WORD
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          rx,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [AW-1:0] wr_ptr,
  output logic          wrap,
  output logic          frame_err
);

  localparam int unsigned LW        = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [7:0]    CNT_HALF  = 8'(CLKS_PER_BIT / 2);
  localparam logic [7:0]    CNT_LAST  = 8'(CLKS_PER_BIT - 1);
  localparam logic [AW-1:0] WRAP_LAST = AW'(WRAP_WORDS - 1);
  localparam logic [LW-1:0] LANE_LAST = LW'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SOUND_STORE_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_RESYNC
  } state_t;

  state_t        state_q;
  logic          rx_meta_q, rx_sync_q;
  logic [7:0]    cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [LW-1:0] lane_q;
  logic [DW-1:0] word_q, word_d;
  logic          wr_en_q;
  logic [DW-1:0] wr_data_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          wrap_q, frame_err_q;
  logic [DW-1:0] rd_data_q;
  logic          bit_tick_c;
`ifdef SOUND_STORE_PARITY_EN
  logic          par_err_q;
`endif

  logic [DW-1:0] mem_q [DEPTH];

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Word with the just-received byte merged into the current lane, and next write pointer.
  always_comb begin
    word_d = word_q;
    for (int i = 0; i < int'(BYTES_PER_WORD); i++) begin
      if (lane_q == LW'(i)) word_d[i*8 +: 8] = shift_q;
    end
    wr_ptr_d   = (wr_ptr_q == WRAP_LAST) ? '0 : wr_ptr_q + AW'(1);
    bit_tick_c = (cnt_q == CNT_LAST);
  end

  // Receive FSM, lane packing, write pointer and event pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      lane_q      <= '0;
      word_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      wr_ptr_q    <= '0;
      wrap_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SOUND_STORE_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      wrap_q      <= 1'b0;
      frame_err_q <= 1'b0;
      wr_en_q     <= 1'b0;
      if (clear) begin
        // Pending write is dropped here and blocked at the RAM port.
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        lane_q   <= '0;
        word_q   <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (wr_en_q) begin
          wr_ptr_q <= wr_ptr_d;
          wrap_q   <= (wr_ptr_q == WRAP_LAST);
        end
        case (state_q)
          S_IDLE: begin
            if (!rx_sync_q) begin
              state_q <= S_START;
              cnt_q   <= '0;
            end
          end
          S_START: begin
            if (cnt_q == CNT_HALF) begin
              cnt_q   <= '0;
              bit_q   <= '0;
              state_q <= rx_sync_q ? S_IDLE : S_DATA;
`ifdef SOUND_STORE_PARITY_EN
              par_err_q <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          S_DATA: begin
            if (bit_tick_c) begin
              cnt_q   <= '0;
              shift_q <= {rx_sync_q, shift_q[7:1]};
              bit_q   <= bit_q + 3'd1;
`ifdef SOUND_STORE_PARITY_EN
              if (bit_q == 3'd7) state_q <= S_PARITY;
`else
              if (bit_q == 3'd7) state_q <= S_STOP;
`endif
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
`ifdef SOUND_STORE_PARITY_EN
          S_PARITY: begin
            if (bit_tick_c) begin
              cnt_q   <= '0;
              state_q <= S_STOP;
              if (rx_sync_q != ^shift_q) begin
                par_err_q   <= 1'b1;
                frame_err_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
`endif
          S_STOP: begin
            if (bit_tick_c) begin
              cnt_q <= '0;
              if (rx_sync_q) begin
                state_q <= S_IDLE;
`ifdef SOUND_STORE_PARITY_EN
                if (!par_err_q) begin
`else
                begin
`endif
                  if (lane_q == LANE_LAST) begin
                    wr_en_q   <= 1'b1;
                    wr_data_q <= word_d;
                    word_q    <= '0;
                    lane_q    <= '0;
                  end else begin
                    word_q <= word_d;
                    lane_q <= lane_q + LW'(1);
                  end
                end
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= S_RESYNC;
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          S_RESYNC: begin
            if (rx_sync_q) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Storage write; a same-cycle clear suppresses it.
  always_ff @(posedge clock) begin
    if (wr_en_q && !clear) mem_q[wr_ptr_q] <= wr_data_q;
  end

  // Registered read port; returns old data on a same-address write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data   = rd_data_q;
  assign wr_ptr    = wr_ptr_q;
  assign wrap      = wrap_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sound_store_rx.sv
// Bench for sound_store_rx: two instances (16-bit words, and byte words with a
// 4-word wrap); expected RAM contents are queued as frames are sent and
// compared through the read port.
module tb_sound_store_rx;

  localparam int unsigned CPB = 8;
`ifdef SOUND_STORE_PARITY_EN
  localparam int unsigned FBITS = 11;
`else
  localparam int unsigned FBITS = 10;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, clear_a, clear_b, rx_a, rx_b;
  logic [9:0]  rd_addr_a, wr_ptr_a;
  logic [15:0] rd_data_a;
  logic        wrap_a, fe_a;
  logic [2:0]  rd_addr_b, wr_ptr_b;
  logic [7:0]  rd_data_b;
  logic        wrap_b, fe_b;

  sound_store_rx #(.CLKS_PER_BIT(CPB), .BYTES_PER_WORD(2), .DEPTH(1024), .WRAP_WORDS(1000)) dut_a (
    .clock(clock), .reset(reset), .clear(clear_a), .rx(rx_a), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .wr_ptr(wr_ptr_a), .wrap(wrap_a), .frame_err(fe_a));

  sound_store_rx #(.CLKS_PER_BIT(CPB), .BYTES_PER_WORD(1), .DEPTH(8), .WRAP_WORDS(4)) dut_b (
    .clock(clock), .reset(reset), .clear(clear_b), .rx(rx_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .wr_ptr(wr_ptr_b), .wrap(wrap_b), .frame_err(fe_b));

  typedef struct {
    int          sel;
    int unsigned addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  // Pulse counters and back-to-back detectors for the one-cycle event outputs.
  int fe_cnt_a = 0, fe_dbl_a = 0, wrap_cnt_b = 0, wrap_dbl_b = 0;
  logic fe_prev_a = 1'b0, wrap_prev_b = 1'b0;
  always @(negedge clock) begin
    if (fe_a) fe_cnt_a++;
    if (fe_a && fe_prev_a) fe_dbl_a++;
    fe_prev_a = fe_a;
    if (wrap_b) wrap_cnt_b++;
    if (wrap_b && wrap_prev_b) wrap_dbl_b++;
    wrap_prev_b = wrap_b;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
  endtask

  task automatic send_frame(input int sel, input logic [7:0] b, input logic stop, input int gap);
    set_rx(sel, 1'b0);
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, b[i]);
      tick(CPB);
    end
`ifdef SOUND_STORE_PARITY_EN
    set_rx(sel, ^b);
    tick(CPB);
`endif
    set_rx(sel, stop);
    tick(CPB);
    set_rx(sel, 1'b1);
    if (gap > 0) tick(gap);
  endtask

`ifdef SOUND_STORE_PARITY_EN
  task automatic send_bad_parity(input int sel, input logic [7:0] b);
    set_rx(sel, 1'b0);
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, b[i]);
      tick(CPB);
    end
    set_rx(sel, ~(^b));
    tick(CPB);
    set_rx(sel, 1'b1);
    tick(CPB + 4);
  endtask
`endif

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel == 0) rd_addr_a = 10'(e.addr);
      else            rd_addr_b = 3'(e.addr);
      tick(2);
      checks++;
      if (e.sel == 0) begin
        if (32'(rd_data_a) !== e.data) begin
          errors++;
          $display("FAIL ram_a[%0d]: got %h expected %h", e.addr, rd_data_a, e.data);
        end
      end else begin
        if (32'(rd_data_b) !== e.data) begin
          errors++;
          $display("FAIL ram_b[%0d]: got %h expected %h", e.addr, rd_data_b, e.data);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    checks++; if (rd_data_a !== 16'h0) begin errors++; $display("FAIL reset rd_data_a: got %h expected 0", rd_data_a); end
    checks++; if (wr_ptr_a !== 10'd0) begin errors++; $display("FAIL reset wr_ptr_a: got %0d expected 0", wr_ptr_a); end
    checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL reset wrap_a: got %b expected 0", wrap_a); end
    checks++; if (fe_a !== 1'b0) begin errors++; $display("FAIL reset frame_err_a: got %b expected 0", fe_a); end
    checks++; if (rd_data_b !== 8'h0) begin errors++; $display("FAIL reset rd_data_b: got %h expected 0", rd_data_b); end
    checks++; if (wr_ptr_b !== 3'd0) begin errors++; $display("FAIL reset wr_ptr_b: got %0d expected 0", wr_ptr_b); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    int fe0;
    fe0 = fe_cnt_a;
    send_frame(0, 8'h34, 1'b1, 4);
    send_frame(0, 8'h12, 1'b1, 4);
    sb.push_back('{0, 0, 32'h1234});
    checks++; if (wr_ptr_a !== 10'd1) begin errors++; $display("FAIL basic wr_ptr: got %0d expected 1", wr_ptr_a); end
    checks++; if (fe_cnt_a - fe0 !== 0) begin errors++; $display("FAIL basic frame_err pulses: got %0d expected 0", fe_cnt_a - fe0); end
    drain();
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt_a;
    rx_a = 1'b0;
    tick(3);
    rx_a = 1'b1;
    tick(20);
    checks++; if (wr_ptr_a !== 10'd1) begin errors++; $display("FAIL glitch wr_ptr: got %0d expected 1", wr_ptr_a); end
    checks++; if (fe_cnt_a - fe0 !== 0) begin errors++; $display("FAIL glitch frame_err pulses: got %0d expected 0", fe_cnt_a - fe0); end
    send_frame(0, 8'h56, 1'b1, 4);
    send_frame(0, 8'h78, 1'b1, 4);
    sb.push_back('{0, 1, 32'h7856});
    checks++; if (wr_ptr_a !== 10'd2) begin errors++; $display("FAIL glitch follow-up wr_ptr: got %0d expected 2", wr_ptr_a); end
    drain();
  endtask

  task automatic test_frame_err();
    int fe0;
    do_reset();
    fe0 = fe_cnt_a;
    send_frame(0, 8'hA5, 1'b0, 12);
    checks++; if (fe_cnt_a - fe0 !== 1) begin errors++; $display("FAIL ferr pulses: got %0d expected 1", fe_cnt_a - fe0); end
    checks++; if (wr_ptr_a !== 10'd0) begin errors++; $display("FAIL ferr wr_ptr: got %0d expected 0", wr_ptr_a); end
    send_frame(0, 8'h01, 1'b1, 4);
    send_frame(0, 8'h02, 1'b1, 4);
    sb.push_back('{0, 0, 32'h0201});
    checks++; if (wr_ptr_a !== 10'd1) begin errors++; $display("FAIL ferr recovery wr_ptr: got %0d expected 1", wr_ptr_a); end
    checks++; if (fe_cnt_a - fe0 !== 1) begin errors++; $display("FAIL ferr later pulses: got %0d expected 1", fe_cnt_a - fe0); end
    checks++; if (fe_dbl_a !== 0) begin errors++; $display("FAIL ferr width: got %0d long pulses expected 0", fe_dbl_a); end
    drain();
  endtask

  task automatic test_wrap();
    int w0;
    do_reset();
    w0 = wrap_cnt_b;
    for (int i = 0; i < 4; i++) begin
      send_frame(1, 8'(8'h10 + i), 1'b1, 4);
      if (i > 0) sb.push_back('{1, i, 32'(8'h10 + i)});
    end
    checks++; if (wrap_cnt_b - w0 !== 1) begin errors++; $display("FAIL wrap pulses after 4: got %0d expected 1", wrap_cnt_b - w0); end
    checks++; if (wr_ptr_b !== 3'd0) begin errors++; $display("FAIL wrap wr_ptr after 4: got %0d expected 0", wr_ptr_b); end
    send_frame(1, 8'h14, 1'b1, 4);
    sb.push_back('{1, 0, 32'h14});
    checks++; if (wr_ptr_b !== 3'd1) begin errors++; $display("FAIL wrap wr_ptr after 5: got %0d expected 1", wr_ptr_b); end
    checks++; if (wrap_cnt_b - w0 !== 1) begin errors++; $display("FAIL wrap pulses after 5: got %0d expected 1", wrap_cnt_b - w0); end
    checks++; if (wrap_dbl_b !== 0) begin errors++; $display("FAIL wrap width: got %0d long pulses expected 0", wrap_dbl_b); end
    drain();
  endtask

  task automatic test_clear();
    do_reset();
    send_frame(0, 8'h11, 1'b1, 4);
    fork
      send_frame(0, 8'h22, 1'b1, 8);
      begin
        tick(CPB * FBITS - 4);
        clear_a = 1'b1;
        tick(8);
        clear_a = 1'b0;
      end
    join
    checks++; if (wr_ptr_a !== 10'd0) begin errors++; $display("FAIL clear wr_ptr: got %0d expected 0", wr_ptr_a); end
    sb.push_back('{0, 0, 32'h0201});
    drain();
    send_frame(0, 8'h66, 1'b1, 4);
    send_frame(0, 8'h55, 1'b1, 4);
    sb.push_back('{0, 0, 32'h5566});
    checks++; if (wr_ptr_a !== 10'd1) begin errors++; $display("FAIL clear next wr_ptr: got %0d expected 1", wr_ptr_a); end
    drain();
  endtask

  task automatic test_back_to_back();
    send_frame(0, 8'hEF, 1'b1, 0);
    send_frame(0, 8'hBE, 1'b1, 0);
    send_frame(0, 8'hAD, 1'b1, 0);
    send_frame(0, 8'hDE, 1'b1, 4);
    sb.push_back('{0, 1, 32'hBEEF});
    sb.push_back('{0, 2, 32'hDEAD});
    checks++; if (wr_ptr_a !== 10'd3) begin errors++; $display("FAIL b2b wr_ptr: got %0d expected 3", wr_ptr_a); end
    drain();
  endtask

`ifdef SOUND_STORE_PARITY_EN
  task automatic test_parity();
    int fe0;
    fe0 = fe_cnt_a;
    send_bad_parity(0, 8'h03);
    checks++; if (fe_cnt_a - fe0 !== 1) begin errors++; $display("FAIL parity pulses: got %0d expected 1", fe_cnt_a - fe0); end
    checks++; if (wr_ptr_a !== 10'd3) begin errors++; $display("FAIL parity wr_ptr: got %0d expected 3", wr_ptr_a); end
    send_frame(0, 8'h03, 1'b1, 4);
    send_frame(0, 8'h04, 1'b1, 4);
    sb.push_back('{0, 3, 32'h0403});
    checks++; if (wr_ptr_a !== 10'd4) begin errors++; $display("FAIL parity good wr_ptr: got %0d expected 4", wr_ptr_a); end
    drain();
  endtask
`endif

  initial begin
    reset     = 1'b1;
    clear_a   = 1'b0;
    clear_b   = 1'b0;
    rx_a      = 1'b1;
    rx_b      = 1'b1;
    rd_addr_a = '0;
    rd_addr_b = '0;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_wrap();
    test_clear();
    test_back_to_back();
`ifdef SOUND_STORE_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sound_store_rx.md
SOUND_STORE_RX -- requirements
Module: sound_store_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 48, clocks per serial bit (range 4..255).
REQ-002 Parameter BYTES_PER_WORD, default 2, bytes packed per stored word (1, 2 or 4 only).
REQ-003 Parameter DEPTH, default 1024, stored words (power of 2); AW = log2(DEPTH).
REQ-004 Parameter WRAP_WORDS, default 1000, words written before the write pointer wraps to 0 (2..DEPTH).
REQ-005 clock  input  1  system clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 clear  input  1  synchronous buffer clear, active-high.
REQ-008 rx  input  1  asynchronous serial line, idle high, 8N1 frame (8E1 with parity, see Configuration).
REQ-009 rd_addr  input  AW  read address.
REQ-010 rd_data  output  8*BYTES_PER_WORD  registered read data.
REQ-011 wr_ptr  output  AW  address of the next word to be written.
REQ-012 wrap  output  1  one-cycle pulse when wr_ptr wraps to 0.
REQ-013 frame_err  output  1  one-cycle pulse on bad stop bit (or parity error).

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer (flops reset to 1); all sampling uses the synchronized value.
REQ-015 FSM states IDLE, START, DATA, PARITY (only when compiled in), STOP, RESYNC.
REQ-016 IDLE: on synchronized rx = 0 go to START with bit counter cleared.
REQ-017 START: at counter = CLKS_PER_BIT/2 (integer divide) sample rx; 0 -> DATA, 1 -> IDLE (glitch rejected, nothing stored).
REQ-018 DATA: sample one bit every CLKS_PER_BIT clocks, LSB first, 8 bits; then STOP (or PARITY).
REQ-019 STOP: sample after CLKS_PER_BIT clocks; 1 -> byte accepted, go IDLE next cycle; 0 -> frame_err pulse, byte discarded, go RESYNC.
REQ-020 RESYNC: remain until synchronized rx = 1, then IDLE.
REQ-021 Accepted bytes SHALL be packed little-endian: first byte to bits [7:0], lane index increments per byte.
REQ-022 When lane BYTES_PER_WORD-1 is filled, the word SHALL be written to RAM[wr_ptr] in the cycle after the stop-bit sample; lane resets to 0.
REQ-023 After each word write wr_ptr increments; if wr_ptr = WRAP_WORDS-1 it becomes 0 and wrap pulses in the same cycle.
REQ-024 A discarded byte SHALL NOT advance the lane; earlier partial lanes remain held.
REQ-025 Read port independent of write; rd_data = RAM[rd_addr] one cycle after rd_addr; a same-cycle read/write to one address returns the old data.
REQ-026 clear SHALL zero wr_ptr and lane, drop any partial word and in-progress frame, and force IDLE; clear wins over a same-cycle word write (no write occurs). RAM contents are unchanged.
REQ-027 wrap and frame_err SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-028 reset SHALL force state IDLE, counters, lane and wr_ptr to 0, wrap = 0, frame_err = 0, synchronizer flops = 1, rd_data = 0.
REQ-029 reset asserted mid-frame SHALL abandon the frame; no RAM write occurs from it. RAM contents are not initialized.

Configuration
REQ-030 Macro SOUND_STORE_PARITY_EN: when defined, the PARITY state samples a ninth bit after the data bits; if it does not equal the even parity of the data, frame_err pulses, the byte is discarded and the FSM still waits for the stop bit; the stop bit is sampled as in REQ-019.
REQ-031 Without SOUND_STORE_PARITY_EN, no PARITY state or parity logic exists; the frame is 8N1.

Verification
REQ-032 CLKS_PER_BIT=8, BPW=2: send 0x34 then 0x12 -> RAM[0]=0x1234, wr_ptr=1, no frame_err.
REQ-033 rx low for 3 clocks then high -> no state beyond START; wr_ptr unchanged; frame_err stays 0.
REQ-034 Send 0xA5 with stop bit 0 -> frame_err one pulse; next good bytes 0x01,0x02 -> RAM[0]=0x0201.
REQ-035 WRAP_WORDS=4, BPW=1: send 5 bytes 0x10..0x14 -> wrap pulses on 4th write, RAM[0]=0x14, wr_ptr=1.
REQ-036 clear asserted in the commit cycle of the second byte (BPW=2) -> no write, wr_ptr=0, next pair lands at RAM[0].
REQ-037 With SOUND_STORE_PARITY_EN, send 0x03 with parity bit 1 -> frame_err pulse, nothing stored; with parity 0 -> byte stored.
